// File: rtl/iomem_timer.sv
// Memory-mapped 32-bit prescaled timer with a sticky compare-match interrupt.
// Bus requests complete with a single-cycle ready pulse, one cycle after valid.
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    logic        sel, accept, wr;
    logic [2:0]  reg_idx;
    logic [31:0] wmask;
    logic        wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
    logic        tick, hit;
    logic [31:0] rd_mux;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, iomem_addr[1:0]};

    always_comb begin
        sel       = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]);
        accept    = sel && !ready_q;
        wr        = accept && (iomem_wstrb != 4'b0000);
        reg_idx   = iomem_addr[4:2];
        wmask     = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                     {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
        wr_ctrl   = wr && (reg_idx == 3'd0);
        wr_presc  = wr && (reg_idx == 3'd1);
        wr_count  = wr && (reg_idx == 3'd2);
        wr_cmp    = wr && (reg_idx == 3'd3);
        wr_status = wr && (reg_idx == 3'd4);
    end

    // A bus write to COUNT overrides the tick, so no match is evaluated that cycle.
    always_comb begin
        tick = ctrl_q[0] && (pcnt_q == prescale_q);
        hit  = tick && !wr_count && (count_q == compare_q);
    end

    always_comb begin
        rd_mux = 32'h0;
        case (reg_idx)
            3'd0:    rd_mux = {29'h0, ctrl_q};
            3'd1:    rd_mux = {16'h0, prescale_q};
            3'd2:    rd_mux = count_q;
            3'd3:    rd_mux = compare_q;
            3'd4:    rd_mux = {31'h0, match_q};
            default: rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;
        ready_d    = accept;
        rdata_d    = accept ? rd_mux : 32'h0;

        if (wr_ctrl && iomem_wstrb[0]) begin
            ctrl_d = iomem_wdata[2:0];
        end
        if (wr_presc) begin
            prescale_d = (prescale_q & ~wmask[15:0]) | (iomem_wdata[15:0] & wmask[15:0]);
        end
        if (wr_cmp) begin
            compare_d = (compare_q & ~wmask) | (iomem_wdata & wmask);
        end

        if (ctrl_q[0]) begin
            pcnt_d = tick ? 16'h0 : pcnt_q + 16'd1;
        end
        if (wr_presc || wr_count) begin
            pcnt_d = 16'h0;
        end

        if (tick) begin
            count_d = (hit && ctrl_q[1]) ? 32'h0 : count_q + 32'd1;
        end
        if (wr_count) begin
            count_d = (count_q & ~wmask) | (iomem_wdata & wmask);
        end

        // Set beats a simultaneous software clear.
        if (wr_status && iomem_wstrb[0] && iomem_wdata[0]) begin
            match_d = 1'b0;
        end
        if (hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= 3'h0;
            prescale_q <= 16'h0;
            pcnt_q     <= 16'h0;
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            match_q    <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = match_q & ctrl_q[2];

endmodule

// File: tb/tb_iomem_timer.sv
// Directed bench for iomem_timer: register access, prescaled matching, wrap and bus decode.
module tb_iomem_timer;

    localparam logic [31:0] B = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        irq;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    iomem_timer #(.BASE_ADDR(B)) dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge where ready drops.
    task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd, output int acc, output logic irq_r);
        int n;
        iomem_addr = a; iomem_wstrb = s; iomem_wdata = d; iomem_valid = 1'b1;
        n = 0; rd = 'x; acc = -1; irq_r = 1'bx;
        do begin
            @(posedge clk); #1; n++;
        end while (!iomem_ready && n < 8);
        chk("ready_latency", n, 1);
        if (iomem_ready) begin
            rd = iomem_rdata; acc = cyc; irq_r = irq;
        end
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        @(posedge clk); #1;
        chk("ready_drop", {31'h0, iomem_ready}, 0);
        chk("rdata_idle", iomem_rdata, 0);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] r; int c; logic ir;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        xfer(a, 4'h0, 32'h0, r, c, ir);
        chk(tag_q.pop_front(), r, exp_q.pop_front());
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r; int c; logic ir;
        xfer(a, s, d, r, c, ir);
    endtask

    task automatic wait_irq(output int c);
        int n;
        n = 0;
        while (!irq && n < 60) begin
            @(posedge clk); #1; n++;
        end
        c = cyc;
        if (!irq) chk("irq_timeout", {31'h0, irq}, 1);
    endtask

    initial begin
        logic [31:0] r;
        int c0, c1, c2, acc;
        logic ir;

        // Reset with a pending request: no ready may be issued.
        iomem_valid = 1'b1; iomem_addr = B;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, iomem_ready}, 0);
        chk("rst_rdata", iomem_rdata, 0);
        chk("rst_irq", {31'h0, irq}, 0);
        iomem_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) rd_chk(B + i * 4, 32'h0, $sformatf("reset_reg%0d", i));

        // Byte strobes and read-zero fields.
        wr(B + 32'h0C, 4'hF, 32'h1234_5678);
        wr(B + 32'h0C, 4'h1, 32'h0000_00A5);
        rd_chk(B + 32'h0C, 32'h1234_56A5, "cmp_byte0");
        wr(B + 32'h0C, 4'h8, 32'hAB00_0000);
        rd_chk(B + 32'h0C, 32'hAB34_56A5, "cmp_byte3");
        wr(B + 32'h04, 4'hF, 32'hFFFF_FFFF);
        rd_chk(B + 32'h04, 32'h0000_FFFF, "presc_hi_zero");
        wr(B + 32'h00, 4'hF, 32'hFFFF_FFF8);
        rd_chk(B + 32'h00, 32'h0, "ctrl_hi_zero");

        // Periodic match: (4+1)*(3+1) = 20 clocks.
        wr(B + 32'h04, 4'hF, 32'd3);
        wr(B + 32'h0C, 4'hF, 32'd4);
        wr(B + 32'h08, 4'hF, 32'd0);
        xfer(B + 32'h00, 4'hF, 32'h7, r, c0, ir);
        wait_irq(c1);
        chk("period_first", c1 - c0, 20);
        rd_chk(B + 32'h08, 32'h0, "count_after_reload");
        xfer(B + 32'h10, 4'h1, 32'h1, r, acc, ir);
        chk("irq_after_clear", {31'h0, ir}, 0);
        wait_irq(c2);
        chk("period_second", c2 - c1, 20);

        // Clear on the same edge as the next match: set wins.
        while (cyc < c2 + 19) begin
            @(posedge clk); #1;
        end
        xfer(B + 32'h10, 4'h1, 32'h1, r, acc, ir);
        chk("set_wins_edge", acc, c2 + 20);
        chk("set_wins_irq", {31'h0, ir}, 1);
        rd_chk(B + 32'h10, 32'h1, "set_wins_status");
        xfer(B + 32'h10, 4'h1, 32'h1, r, acc, ir);
        chk("late_clear_irq", {31'h0, ir}, 0);
        chk("late_clear_irq_next", {31'h0, irq}, 0);

        // Wrap through zero with PRESCALE = 0 and RELOAD = 0.
        wr(B + 32'h00, 4'hF, 32'h0);
        wr(B + 32'h10, 4'h1, 32'h1);
        wr(B + 32'h04, 4'hF, 32'h0);
        wr(B + 32'h0C, 4'hF, 32'd5);
        wr(B + 32'h08, 4'hF, 32'hFFFF_FFFF);
        xfer(B + 32'h00, 4'hF, 32'h5, r, c0, ir);
        rd_chk(B + 32'h08, 32'h0, "wrap_zero");
        rd_chk(B + 32'h08, 32'd2, "wrap_run");
        wait_irq(c1);
        chk("wrap_match_edge", c1 - c0, 7);
        rd_chk(B + 32'h08, 32'd6, "count_after_match");

        // Bus decode: outside window ignored, unused offsets answer with zero.
        wr(B + 32'h00, 4'hF, 32'h0);
        iomem_addr = 32'h0400_000C; iomem_wstrb = 4'hF; iomem_wdata = 32'h0;
        iomem_valid = 1'b1;
        c0 = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (iomem_ready) c0++;
        end
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        chk("unsel_no_ready", c0, 0);
        @(posedge clk); #1;
        wr(B + 32'h18, 4'hF, 32'hDEAD_BEEF);
        rd_chk(B + 32'h18, 32'h0, "off18_zero");
        rd_chk(B + 32'h0C, 32'd5, "cmp_untouched");
        rd_chk(B + 32'h04, 32'h0, "presc_untouched");
        rd_chk(B + 32'h00, 32'h0, "ctrl_untouched");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iomem_timer.md
# iomem_timer

Memory-mapped 32-bit timer/compare peripheral on the SoC's `iomem_*` bus, in the external I/O window above `0x0200_00FF`. It counts prescaled clock ticks and raises a sticky compare-match interrupt, driven into the SoC's `irq_5` input. Firmware gets a periodic or one-shot time base without polling. Bus responses use the SoC's valid/ready convention with one cycle of latency.

## Interface
- `BASE_ADDR`, default `32'h0300_0000`: base of the 32-byte register window; must be 32-byte aligned.
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `iomem_valid` in 1: bus request, held by master until `iomem_ready`.
- `iomem_ready` out 1: one-cycle completion pulse.
- `iomem_wstrb` in 4: byte write strobes; `0` means read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready` = 1.
- `irq` out 1: level interrupt, `MATCH & IE`.

## Operation
- Select: `sel = iomem_valid && iomem_addr[31:5] == BASE_ADDR[31:5]`.
  - Unselected requests are ignored, with no ready and no side effects.
- Register offsets (`addr[4:2]`):
  - 0x00 `CTRL`: bit0 `EN`, bit1 `RELOAD`, bit2 `IE`; bits 31:3 read 0.
  - 0x04 `PRESCALE[15:0]`: bits 31:16 read 0. Writing any byte also clears the internal prescale counter `pcnt`.
  - 0x08 `COUNT[31:0]`: read returns the live count; write loads it and clears `pcnt`.
  - 0x0C `COMPARE[31:0]`.
  - 0x10 `STATUS`: bit0 `MATCH`, sticky. Writing 1 to bit0 with `wstrb[0]` set clears it; writing 0 has no effect.
  - 0x14–0x1C: read `0`, writes ignored, ready still returned.
- Writes honor byte strobes individually. Bytes whose strobe is clear keep their value.
- Counting applies only while `EN` = 1:
  - Each clock, if `pcnt == PRESCALE` then `pcnt <= 0` and `tick` = 1; otherwise `pcnt <= pcnt + 1`.
  - On `tick`, if `COUNT == COMPARE`:
    - `MATCH <= 1`.
    - `COUNT <= RELOAD ? 0 : COUNT + 1`.
  - On `tick` with no match: `COUNT <= COUNT + 1`, 32-bit wrap (`0xFFFF_FFFF` → `0`). No overflow flag.
  - `EN` = 0: `COUNT` and `pcnt` hold, no ticks.
  - `PRESCALE` = 0 ticks every enabled clock.
- Simultaneous events:
  - Bus write to `COUNT` and `tick` in the same cycle: bus value wins, no increment, no match evaluation that cycle.
  - `STATUS` clear and new match in the same cycle: `MATCH` ends at 1 (set wins).
  - Write to `PRESCALE` and `tick` in the same cycle: the `tick` is still applied to `COUNT`, and `pcnt` ends at 0.
  - Writing `COMPARE` takes effect for the next tick evaluation.
- `irq` is combinational from registered `MATCH` and `IE`, with no extra delay.

## Timing
- Request accepted on a rising edge where `sel && !iomem_ready`.
  - On that same edge: the write commits, `iomem_rdata` is captured (pre-write value of the addressed register), and `iomem_ready <= 1`.
  - The next edge forces `iomem_ready <= 0`.
- Latency: `iomem_ready` is high exactly in the cycle after `valid` is first sampled. Back-to-back requests complete every 2 cycles.
- A `valid` still high during the ready cycle is not re-accepted (guarded by `!iomem_ready`).
- `iomem_rdata` is 0 whenever `iomem_ready` = 0.
- A `COUNT` read returns the value before that edge's increment.
- Timer period with `RELOAD` = 1: `(COMPARE + 1) * (PRESCALE + 1)` clocks between `MATCH` sets.
- Reset values: `iomem_ready` = 0, `iomem_rdata` = 0, `irq` = 0, and `CTRL`, `PRESCALE`, `COUNT`, `COMPARE`, `STATUS`, `pcnt` all = 0.
- Reset asserted mid-transaction aborts it: no ready is issued, and the master retries after reset.

## Test plan
- Reset then read all 8 offsets → each returns `0`, with `iomem_ready` high exactly one cycle after `valid`.
- Write `0x0000_00A5` to `COMPARE` with `wstrb` = `4'b0001`, after `COMPARE` = `0x1234_5678` → readback `0x1234_56A5`.
- `PRESCALE` = 3, `COMPARE` = 4, `CTRL` = `0x7` → `MATCH` and `irq` rise 20 clocks after enable. `COUNT` reads `0` right after the match, and `MATCH` sets again 20 clocks later.
- `COUNT` = `0xFFFF_FFFF`, `PRESCALE` = 0, `RELOAD` = 0, `COMPARE` = 5, `EN` = 1 → next tick `COUNT` = `0`. `MATCH` sets on the tick where `COUNT` = 5, and the following tick gives `COUNT` = 6.
- Write `STATUS` = 1 on the same edge as a match tick → `MATCH` stays 1 and `irq` stays high. A later clear with no match → `irq` drops the cycle after the ready edge.
- Write to `0x0400_0000`, then to offset `0x18` → the first gets no `iomem_ready` over 10 cycles. The second gets ready, reads back `0`, and no register changes.
